rgb_layer_compositor: RTL and testbench
=======================================

Name: rgb_layer_compositor

Overview:
- Parametrised, pipelined successor to the team's combinational RGB OR-merge of sprite layers (player, header, bullet, enemy).
- Merges NUM_LAYERS colour layers per pixel in one of two modes: OR blend or fixed priority.
- Transparent pixels fall back to a programmable background colour.
- Accumulates per-frame, per-layer collision (overlap) flags for game logic.
- Sits between the sprite/layer generators and the VGA output stage.

Parameters:
- NUM_LAYERS, 4: number of input layers, legal range 2..8; layer 0 is highest priority.
- COLOR_W, 6: bits per pixel colour (RRGGBB for the default).
- PRIORITY_MODE, 0: 0 = bitwise OR of enabled layers; 1 = first opaque layer by priority wins.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- pix_valid  in  1  input pixel qualifier.
- layer_rgb  in  NUM_LAYERS*COLOR_W  packed layer colours; layer i occupies bits [i*COLOR_W +: COLOR_W].
- layer_en  in  NUM_LAYERS  per-layer enable; a disabled layer is treated as transparent.
- bg_rgb  in  COLOR_W  background colour, sampled together with the pixel.
- frame_start  in  1  single-cycle pulse that closes the current frame's collision window.
- rgb_out  out  COLOR_W  composited colour.
- rgb_valid  out  1  qualifier for rgb_out.
- collision_flags  out  NUM_LAYERS  per-layer overlap flags for the last completed frame.
- collision_any  out  1  OR of collision_flags.
- frame_done  out  1  one-cycle pulse when collision_flags updates.

Behaviour:
- Reset: rgb_out=0, rgb_valid=0, collision_flags=0, collision_any=0, frame_done=0. The internal accumulator and both pipeline stages clear. Pixels in flight are dropped, with no partial output.
- Opaque rule: layer i is opaque when layer_en[i]=1 and its colour is non-zero. All-zero colour means transparent.
- Stage 1 (cycle t+1), registered:
  - masked colours (colour & {COLOR_W{en}});
  - opaque vector;
  - bg_rgb;
  - valid = pix_valid.
- Stage 2 (cycle t+2), registered: rgb_out and rgb_valid. Latency is exactly 2 cycles, throughput one pixel per clock, with no backpressure.
- OR mode: rgb_out = OR of all masked colours. If the result is 0, rgb_out = bg_rgb.
- Priority mode: rgb_out = colour of the lowest-index opaque layer. If no layer is opaque, rgb_out = bg_rgb.
- When stage-1 valid=0: rgb_valid=0 and rgb_out holds its previous value.
- Collision detection:
  - A stage-1 pixel with valid=1 and two or more opaque layers ORs its opaque vector into the accumulator.
  - A pixel with one or zero opaque layers contributes nothing.
- frame_start asserted in cycle t, at the next edge:
  - collision_flags <= accumulator | contribution of the pixel currently in stage 1 (that pixel belongs to the old frame);
  - accumulator <= 0;
  - frame_done <= 1 for one cycle;
  - collision_any <= OR of the new flags.
- A pixel presented with frame_start in the same cycle belongs to the new frame.
- Back-to-back frame_start pulses are legal. The second pulse publishes only the stage-1 contribution, which may be 0.
- collision_flags hold between frame_start pulses.
- reset has priority over frame_start.
- A pixel stream with pix_valid gaps does not affect the accumulator.
- layer_en and bg_rgb are sampled per pixel. Changing them has no effect on pixels already in flight.

Decomposition:
- Shared package/header holds:
  - the COLOR_W default;
  - the TRANSPARENT constant (all zeros);
  - PRIO_MODE_OR=0 and PRIO_MODE_PRIORITY=1;
  - the layer-index localparams (PLAYER=0, BULLET=1, ENEMY0=2, HEADER=3).
- One sub-module, layer_priority_select: a combinational first-opaque-index selector, parametrised by NUM_LAYERS, that outputs the index and a found flag.
- Collision accumulation and the pipeline stay in the top module.

Test Plan:
- Reset then idle: reset high for 3 cycles with pix_valid=1 → all outputs 0 throughout and for 2 cycles after release.
- OR mode, layers = {0x00,0x30,0x0C,0x00}, all enabled, bg=0x01 → rgb_out=0x3C with rgb_valid exactly 2 cycles after the input; all layers 0 → rgb_out=0x01.
- Priority mode, layers = {0x00,0x30,0x0C,0x03} → rgb_out=0x30 (layer 1). Same input with layer_en=4'b1101 → rgb_out=0x0C.
- Collision: within one frame, pixels with layers 0 and 2 overlapping, then 1 and 3 overlapping, then frame_start → next cycle collision_flags=4'b1111, collision_any=1, frame_done=1 for one cycle. A following frame with no overlap, then frame_start → flags=0.
- Boundary: overlapping pixel (layers 0 and 1) in cycle t, frame_start in cycle t+1 → counted in the old frame, flags=4'b0011. Overlap presented together with frame_start → appears only at the next frame_start.
- Reset mid-stream: reset asserted while 2 valid pixels are in flight and the accumulator is non-zero → no rgb_valid pulses afterwards; next frame_start publishes 0.

Source files
------------

// File: rtl/rgb_layer_compositor_pkg.sv
// Shared constants for the RGB layer compositor: colour width, blend modes
// and the game's layer index map.
package rgb_layer_compositor_pkg;
  localparam int COLOR_W_DEF = 6;
  localparam logic [COLOR_W_DEF-1:0] TRANSPARENT = '0;

  localparam int PRIO_MODE_OR       = 0;
  localparam int PRIO_MODE_PRIORITY = 1;

  // Layer slots as wired by the sprite generators; lower index wins in priority mode.
  localparam int PLAYER = 0;
  localparam int BULLET = 1;
  localparam int ENEMY0 = 2;
  localparam int HEADER = 3;
endpackage

// File: rtl/rgb_layer_compositor_if.sv
// Pixel-stream bundle between the layer generators, the compositor and the VGA stage.
interface rgb_layer_compositor_if #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = 6
);
  logic                          pix_valid;
  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb;
  logic [NUM_LAYERS-1:0]         layer_en;
  logic [COLOR_W-1:0]            bg_rgb;
  logic                          frame_start;
  logic [COLOR_W-1:0]            rgb_out;
  logic                          rgb_valid;
  logic [NUM_LAYERS-1:0]         collision_flags;
  logic                          collision_any;
  logic                          frame_done;

  modport master (
    output pix_valid, layer_rgb, layer_en, bg_rgb, frame_start,
    input  rgb_out, rgb_valid, collision_flags, collision_any, frame_done
  );

  modport slave (
    input  pix_valid, layer_rgb, layer_en, bg_rgb, frame_start,
    output rgb_out, rgb_valid, collision_flags, collision_any, frame_done
  );
endinterface

// File: rtl/rgb_layer_compositor_priority_select.sv
// Combinational first-opaque finder: lowest set bit of the opaque vector.
module layer_priority_select
  import rgb_layer_compositor_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int IDX_W      = $clog2(NUM_LAYERS)
) (
  input  logic [NUM_LAYERS-1:0] opaque,
  output logic [IDX_W-1:0]      idx,
  output logic                  found
);
  // Scan high to low so the last hit, the lowest index, is what sticks.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (opaque[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rgb_layer_compositor.sv
// Two-stage layer compositor: mask/opacity in stage 1, blend + background in
// stage 2, with a per-frame collision accumulator fed from stage 1.
module rgb_layer_compositor
  import rgb_layer_compositor_pkg::*;
#(
  parameter int NUM_LAYERS    = 4,
  parameter int COLOR_W       = COLOR_W_DEF,
  parameter int PRIORITY_MODE = PRIO_MODE_OR
) (
  input logic                  clk,
  input logic                  reset,
  rgb_layer_compositor_if.slave bus
);
  localparam int STAGES = 2;
  localparam int IDX_W  = $clog2(NUM_LAYERS);

  logic [STAGES:0]                       vld_pipe;
  logic [STAGES:1]                       vld_q;
  logic [NUM_LAYERS-1:0][COLOR_W-1:0]    in_rgb, s1_rgb;
  logic [NUM_LAYERS-1:0]                 in_opq, s1_opq;
  logic [COLOR_W-1:0]                    s1_bg;

  assign vld_pipe = {vld_q, bus.pix_valid};

  // Disabled layers are zeroed here, so "opaque" reduces to a non-zero check.
  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_lane
    assign in_rgb[g] = bus.layer_rgb[g*COLOR_W +: COLOR_W] & {COLOR_W{bus.layer_en[g]}};
    assign in_opq[g] = (in_rgb[g] != COLOR_W'(TRANSPARENT));
  end

  // Stage 1
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q[1] <= 1'b0;
      s1_rgb   <= '0;
      s1_opq   <= '0;
      s1_bg    <= '0;
    end else begin
      vld_q[1] <= vld_pipe[0];
      s1_rgb   <= in_rgb;
      s1_opq   <= in_opq;
      s1_bg    <= bus.bg_rgb;
    end
  end

  logic [IDX_W-1:0]   sel_idx;
  logic               sel_found;
  logic [COLOR_W-1:0] or_rgb, blend_rgb;

  layer_priority_select #(.NUM_LAYERS(NUM_LAYERS), .IDX_W(IDX_W)) u_sel (
    .opaque (s1_opq),
    .idx    (sel_idx),
    .found  (sel_found)
  );

  always_comb begin
    or_rgb = '0;
    for (int i = 0; i < NUM_LAYERS; i++) or_rgb |= s1_rgb[i];
    if (PRIORITY_MODE == PRIO_MODE_PRIORITY)
      blend_rgb = sel_found ? s1_rgb[sel_idx] : s1_bg;
    else
      blend_rgb = (or_rgb != COLOR_W'(TRANSPARENT)) ? or_rgb : s1_bg;
  end

  // Stage 2: colour only updates on valid pixels, so gaps hold the last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q[2]    <= 1'b0;
      bus.rgb_out <= '0;
    end else begin
      vld_q[2] <= vld_pipe[1];
      if (vld_pipe[1]) bus.rgb_out <= blend_rgb;
    end
  end

  assign bus.rgb_valid = vld_pipe[STAGES];

  logic [NUM_LAYERS-1:0] acc, contrib, publish;
  logic                  multi_opq;

  // x & (x-1) is non-zero exactly when two or more layers are opaque.
  assign multi_opq = ((s1_opq & (s1_opq - NUM_LAYERS'(1))) != '0);
  assign contrib   = (vld_pipe[1] && multi_opq) ? s1_opq : '0;
  assign publish   = acc | contrib;

  // The stage-1 pixel at a frame_start edge still belongs to the closing frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc                 <= '0;
      bus.collision_flags <= '0;
      bus.collision_any   <= 1'b0;
      bus.frame_done      <= 1'b0;
    end else if (bus.frame_start) begin
      acc                 <= '0;
      bus.collision_flags <= publish;
      bus.collision_any   <= |publish;
      bus.frame_done      <= 1'b1;
    end else begin
      acc                 <= publish;
      bus.frame_done      <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rgb_layer_compositor.sv
// Bench for rgb_layer_compositor: OR and priority instances share stimulus; a
// history-based reference model checks every cycle, plus table and corner sequences.
module tb_rgb_layer_compositor;
  localparam int NL   = 4;
  localparam int CW   = 6;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset = 1'b1;
  logic                 pix_valid = 1'b1;
  logic [NL*CW-1:0]     layer_rgb = {6'h3F, 6'h15, 6'h2A, 6'h01};
  logic [NL-1:0]        layer_en = 4'hF;
  logic [CW-1:0]        bg_rgb = 6'h05;
  logic                 frame_start = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  rgb_layer_compositor_if #(.NUM_LAYERS(NL), .COLOR_W(CW)) ifo ();
  rgb_layer_compositor_if #(.NUM_LAYERS(NL), .COLOR_W(CW)) ifp ();

  assign ifo.pix_valid = pix_valid;  assign ifp.pix_valid = pix_valid;
  assign ifo.layer_rgb = layer_rgb;  assign ifp.layer_rgb = layer_rgb;
  assign ifo.layer_en  = layer_en;   assign ifp.layer_en  = layer_en;
  assign ifo.bg_rgb    = bg_rgb;     assign ifp.bg_rgb    = bg_rgb;
  assign ifo.frame_start = frame_start;
  assign ifp.frame_start = frame_start;

  rgb_layer_compositor #(.NUM_LAYERS(NL), .COLOR_W(CW), .PRIORITY_MODE(0)) dut_or (
    .clk(clk), .reset(reset), .bus(ifo));
  rgb_layer_compositor #(.NUM_LAYERS(NL), .COLOR_W(CW), .PRIORITY_MODE(1)) dut_pri (
    .clk(clk), .reset(reset), .bus(ifp));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [CW-1:0] compose(input logic [NL*CW-1:0] rgb, input logic [NL-1:0] en,
                                            input logic [CW-1:0] bg, input bit prio);
    logic [CW-1:0] c, acc;
    acc = '0;
    for (int i = 0; i < NL; i++) begin
      c = rgb[i*CW +: CW];
      if (en[i]) begin
        if (prio && c != 0) return c;
        acc |= c;
      end
    end
    if (prio) return bg;
    return (acc == 0) ? bg : acc;
  endfunction

  function automatic logic [NL-1:0] coll(input logic [NL*CW-1:0] rgb, input logic [NL-1:0] en);
    logic [NL-1:0] m;
    int cnt;
    m = '0; cnt = 0;
    for (int i = 0; i < NL; i++)
      if (en[i] && rgb[i*CW +: CW] != 0) begin m[i] = 1'b1; cnt++; end
    return (cnt >= 2) ? m : '0;
  endfunction

  logic             h_vld[MAXC];
  logic [NL*CW-1:0] h_rgb[MAXC];
  logic [NL-1:0]    h_en[MAXC];
  logic [CW-1:0]    h_bg[MAXC];
  logic             h_fs[MAXC];
  logic             h_rst[MAXC];
  int cyc = 0, e_idx = 0, last_clear = 0;
  logic [CW-1:0] m_rgb_o = '0, m_rgb_p = '0;
  logic          m_vld = 1'b0, m_done = 1'b0;
  logic [NL-1:0] m_flags = '0;

  // Each edge e consumes the inputs recorded at e; outputs are checked 1 time unit later.
  always @(posedge clk) begin
    if (cyc < MAXC) begin
      e_idx = cyc;
      h_vld[e_idx] = pix_valid; h_rgb[e_idx] = layer_rgb; h_en[e_idx] = layer_en;
      h_bg[e_idx] = bg_rgb; h_fs[e_idx] = frame_start; h_rst[e_idx] = reset;
      cyc++;
      #1;
      if (h_rst[e_idx]) begin
        m_rgb_o = '0; m_rgb_p = '0; m_vld = 1'b0; m_flags = '0; m_done = 1'b0;
        last_clear = e_idx;
      end else begin
        m_vld = 1'b0;
        if (e_idx >= 1) m_vld = h_vld[e_idx-1] && !h_rst[e_idx-1];
        if (m_vld) begin
          m_rgb_o = compose(h_rgb[e_idx-1], h_en[e_idx-1], h_bg[e_idx-1], 1'b0);
          m_rgb_p = compose(h_rgb[e_idx-1], h_en[e_idx-1], h_bg[e_idx-1], 1'b1);
        end
        m_done = h_fs[e_idx];
        if (h_fs[e_idx]) begin
          // Pixels from the last clear up to the one in stage 1 form the closing frame.
          m_flags = '0;
          for (int c = last_clear; c < e_idx; c++)
            if (h_vld[c] && !h_rst[c]) m_flags |= coll(h_rgb[c], h_en[c]);
          last_clear = e_idx;
        end
      end
      chk("model rgb_out or",   32'(ifo.rgb_out),   32'(m_rgb_o));
      chk("model rgb_out pri",  32'(ifp.rgb_out),   32'(m_rgb_p));
      chk("model rgb_valid or", 32'(ifo.rgb_valid), 32'(m_vld));
      chk("model rgb_valid pri",32'(ifp.rgb_valid), 32'(m_vld));
      chk("model flags or",     32'(ifo.collision_flags), 32'(m_flags));
      chk("model flags pri",    32'(ifp.collision_flags), 32'(m_flags));
      chk("model any",          32'(ifo.collision_any),   32'(|m_flags));
      chk("model frame_done",   32'(ifo.frame_done),      32'(m_done));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input logic rst, input logic v, input logic [NL*CW-1:0] rgb,
                     input logic [NL-1:0] en, input logic [CW-1:0] bg, input logic fs);
    @(negedge clk);
    reset = rst; pix_valid = v; layer_rgb = rgb; layer_en = en; bg_rgb = bg; frame_start = fs;
  endtask

  task automatic idle(input logic fs);
    drv(1'b0, 1'b0, '0, 4'hF, 6'h00, fs);
  endtask

  task automatic px(input logic [NL*CW-1:0] rgb, input logic fs);
    drv(1'b0, 1'b1, rgb, 4'hF, 6'h00, fs);
  endtask

  task automatic after_edge();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [NL*CW-1:0] rgb;
    logic [NL-1:0]    en;
    logic [CW-1:0]    bg;
    logic [CW-1:0]    exp_or;
    logic [CW-1:0]    exp_pri;
  } vec_t;
  vec_t tbl[9];

  initial begin
    logic [NL*CW-1:0] rr;
    tbl[0] = '{{6'h00, 6'h0C, 6'h30, 6'h00}, 4'hF,    6'h01, 6'h3C, 6'h30};
    tbl[1] = '{{6'h00, 6'h00, 6'h00, 6'h00}, 4'hF,    6'h01, 6'h01, 6'h01};
    tbl[2] = '{{6'h03, 6'h0C, 6'h30, 6'h00}, 4'hF,    6'h01, 6'h3F, 6'h30};
    tbl[3] = '{{6'h03, 6'h0C, 6'h30, 6'h00}, 4'b1101, 6'h01, 6'h0F, 6'h0C};
    tbl[4] = '{{6'h3F, 6'h3F, 6'h3F, 6'h3F}, 4'h0,    6'h2A, 6'h2A, 6'h2A};
    tbl[5] = '{{6'h3F, 6'h00, 6'h2A, 6'h15}, 4'hF,    6'h00, 6'h3F, 6'h15};
    tbl[6] = '{{6'h07, 6'h00, 6'h00, 6'h00}, 4'b1000, 6'h11, 6'h07, 6'h07};
    tbl[7] = '{{6'h07, 6'h00, 6'h00, 6'h00}, 4'b0111, 6'h11, 6'h11, 6'h11};
    tbl[8] = '{{6'h00, 6'h00, 6'h20, 6'h00}, 4'hF,    6'h3F, 6'h20, 6'h20};

    // Reset held 3 edges with a valid pixel presented: everything stays 0.
    repeat (3) begin
      after_edge();
      chk("reset rgb_valid", 32'(ifo.rgb_valid), 0);
      chk("reset rgb_out",   32'(ifo.rgb_out), 0);
      chk("reset flags",     32'(ifo.collision_flags), 0);
      chk("reset frame_done",32'(ifo.frame_done), 0);
    end
    repeat (2) begin
      idle(1'b0); after_edge();
      chk("post-reset rgb_valid", 32'(ifo.rgb_valid), 0);
      chk("post-reset rgb_out",   32'(ifp.rgb_out), 0);
    end

    // Table vectors: one pixel between idles, result exactly 2 edges later.
    for (int k = 0; k < 9; k++) begin
      drv(1'b0, 1'b1, tbl[k].rgb, tbl[k].en, tbl[k].bg, 1'b0);
      after_edge();
      chk("tbl early valid", 32'(ifo.rgb_valid), 0);
      idle(1'b0); after_edge();
      chk("tbl valid or",  32'(ifo.rgb_valid), 1);
      chk("tbl valid pri", 32'(ifp.rgb_valid), 1);
      chk("tbl rgb or",    32'(ifo.rgb_out), 32'(tbl[k].exp_or));
      chk("tbl rgb pri",   32'(ifp.rgb_out), 32'(tbl[k].exp_pri));
    end

    // Collision: overlaps on {0,2} and {1,3} in one frame.
    idle(1'b1);
    px({6'h00, 6'h02, 6'h00, 6'h01}, 1'b0);
    px({6'h08, 6'h00, 6'h04, 6'h00}, 1'b0);
    idle(1'b1); after_edge();
    chk("coll flags", 32'(ifo.collision_flags), 32'hF);
    chk("coll any",   32'(ifo.collision_any), 1);
    chk("coll done",  32'(ifo.frame_done), 1);
    idle(1'b0); after_edge();
    chk("coll done pulse", 32'(ifo.frame_done), 0);
    chk("coll flags hold", 32'(ifo.collision_flags), 32'hF);
    px({6'h00, 6'h00, 6'h00, 6'h01}, 1'b0);
    px({6'h00, 6'h00, 6'h04, 6'h00}, 1'b0);
    px({6'h00, 6'h00, 6'h00, 6'h00}, 1'b0);
    idle(1'b1); after_edge();
    chk("clean frame flags", 32'(ifo.collision_flags), 0);
    chk("clean frame any",   32'(ifo.collision_any), 0);
    chk("clean frame done",  32'(ifo.frame_done), 1);

    // Boundary: overlap one cycle before frame_start counts in the old frame.
    px({6'h00, 6'h00, 6'h04, 6'h01}, 1'b0);
    idle(1'b1); after_edge();
    chk("boundary old frame", 32'(ifo.collision_flags), 32'h3);
    px({6'h08, 6'h02, 6'h00, 6'h00}, 1'b1); after_edge();
    chk("boundary same-cycle", 32'(ifo.collision_flags), 0);
    idle(1'b0);
    idle(1'b1); after_edge();
    chk("boundary next frame", 32'(ifo.collision_flags), 32'hC);
    idle(1'b1); after_edge();
    chk("back-to-back flags", 32'(ifo.collision_flags), 0);
    chk("back-to-back done",  32'(ifo.frame_done), 1);

    // Reset with two valid pixels in flight and a non-empty accumulator.
    idle(1'b0);
    px({6'h00, 6'h00, 6'h04, 6'h01}, 1'b0);
    px({6'h08, 6'h02, 6'h00, 6'h00}, 1'b0);
    px({6'h00, 6'h10, 6'h00, 6'h01}, 1'b0);
    drv(1'b1, 1'b0, '0, 4'hF, 6'h00, 1'b1); after_edge();
    chk("midreset valid", 32'(ifo.rgb_valid), 0);
    chk("midreset done",  32'(ifo.frame_done), 0);
    repeat (3) begin
      idle(1'b0); after_edge();
      chk("midreset drain", 32'(ifo.rgb_valid) | 32'(ifp.rgb_valid), 0);
    end
    idle(1'b1); after_edge();
    chk("midreset publish", 32'(ifo.collision_flags), 0);
    chk("midreset pub done", 32'(ifo.frame_done), 1);

    // Randomised traffic, checked by the reference model every edge.
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NL; i++)
        rr[i*CW +: CW] = ($urandom_range(0, 1) == 0) ? 6'h00 : CW'($urandom);
      drv(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), rr,
          NL'($urandom), CW'($urandom), ($urandom_range(0, 15) == 0));
    end
    repeat (4) idle(1'b0);
    after_edge();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
